// File: rtl/uart_mmio.sv
// Memory-mapped UART (TXD/RXD/CON) for the CPU MEM stage: 8N1 framing, fixed baud divider,
// read-to-clear status flags and a registered level interrupt.
module uart_mmio #(
  parameter int          BAUD_DIV  = 5208,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq_out
);

  localparam int          CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] TXD_A = BASE_ADDR;
  localparam logic [31:0] RXD_A = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_A = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          uart_tx_q;

  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rxd_q;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;

  logic tx_ie_q, rx_ie_q, tx_done_q, rx_valid_q, irq_q;
  logic tx_done_d, rx_valid_d;

  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic tx_busy, tx_fin, rx_ok;
  logic unused_wdata;

  assign wr_txd       = wr && (addr == TXD_A);
  assign wr_con       = wr && (addr == CON_A);
  assign rd_rxd       = rd && (addr == RXD_A);
  assign rd_con       = rd && (addr == CON_A);
  assign unused_wdata = ^wdata[31:8];

  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_fin  = (tx_state_q == TX_STOP) && (tx_cnt_q == LAST);
  assign rx_ok   = (rx_state_q == RX_STOP) && (rx_cnt_q == LAST) && rx_s2_q;

  assign uart_tx = uart_tx_q;
  assign irq_out = irq_q;

  // Transmitter: uart_tx_q is loaded with the next line level as each bit period ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_txd) begin
            tx_shift_q <= wdata[7:0];
            tx_cnt_q   <= '0;
            uart_tx_q  <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            uart_tx_q  <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              uart_tx_q  <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              uart_tx_q  <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Receiver: rx_s3_q is the previous synchronized level, used only for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rxd_q      <= '0;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s2_q) rxd_q <= rx_shift_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // A flag being set on the same edge as its read-clear stays set.
  always_comb begin
    tx_done_d  = tx_done_q;
    rx_valid_d = rx_valid_q;
    if (rd_con)            tx_done_d  = 1'b0;
    if (tx_fin)            tx_done_d  = 1'b1;
    if (rd_con || rd_rxd)  rx_valid_d = 1'b0;
    if (rx_ok)             rx_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_ie_q    <= 1'b0;
      rx_ie_q    <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_con) begin
        tx_ie_q <= wdata[0];
        rx_ie_q <= wdata[1];
      end
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      irq_q      <= (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_rxd)      rdata = {24'h0, rxd_q};
    else if (rd_con) rdata = {27'h0, tx_busy, rx_valid_q, tx_done_q, rx_ie_q, tx_ie_q};
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: bus/serial driver tasks, a register-level reference model,
// scoreboard queues for load data and transmitted frames, and monitors that pop and compare.
module tb_uart_mmio;

  localparam int          BD    = 16;
  localparam int          FRAME = 10 * BD;
  localparam logic [31:0] BASE  = 32'h40000018;
  localparam logic [31:0] TXD_A = BASE;
  localparam logic [31:0] RXD_A = BASE + 32'd4;
  localparam logic [31:0] CON_A = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        irq_out;

  uart_mmio #(.BAUD_DIV(BD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_out(irq_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: transmitted frames as {start_cycle, byte}, load data per checked read.
  logic [39:0] exp_q[$];
  logic [31:0] exp_rd_q[$];
  logic        rd_chk = 1'b0;

  // Reference model of the register file at the level of the register map.
  bit         m_tx_ie, m_rx_ie, m_tx_done, m_rx_valid, m_tx_active;
  int         m_tx_end;
  logic [7:0] m_rxd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  function automatic void model_reset();
    m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_valid = 0; m_tx_active = 0;
    m_tx_end = 0; m_rxd = 8'h00;
  endfunction

  // A frame started at write-edge N ends at edge N+FRAME; m_tx_end holds that edge.
  function automatic void model_advance();
    if (m_tx_active && cyc >= m_tx_end) begin
      m_tx_active = 0;
      m_tx_done   = 1;
    end
  endfunction

  function automatic logic [31:0] model_con();
    model_advance();
    return {27'h0, m_tx_active, m_rx_valid, m_tx_done, m_rx_ie, m_tx_ie};
  endfunction

  function automatic logic model_irq();
    model_advance();
    return (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_valid);
  endfunction

  // ---------------- driver tasks (all start and end #1 after a rising edge) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    model_advance();
    if (a == TXD_A && !m_tx_active) begin
      m_tx_active = 1;
      m_tx_end    = cyc + 1 + FRAME;
      exp_q.push_back({32'(cyc + 1), d[7:0]});
    end
    if (a == CON_A) begin
      m_tx_ie = d[0];
      m_rx_ie = d[1];
    end
    addr = a; wdata = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    logic [31:0] e;
    if (a == RXD_A)      e = {24'h0, m_rxd};
    else if (a == CON_A) e = model_con();
    else                 e = 32'h0;
    exp_rd_q.push_back(e);
    addr = a; rd = 1'b1; rd_chk = 1'b1;
    tick(1);
    rd = 1'b0; rd_chk = 1'b0;
    if (a == CON_A) begin m_tx_done = 0; m_rx_valid = 0; end
    if (a == RXD_A) m_rx_valid = 0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      uart_rx = 1'b0;
      else if (i == 9) uart_rx = stop;
      else             uart_rx = b[i-1];
      tick(BD);
    end
    uart_rx = 1'b1;
    if (stop) begin
      m_rx_valid = 1;
      m_rxd      = b;
    end
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge clk);
    if (rd && rd_chk) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected: read of 0x%0h with no expectation queued", addr);
      end else begin
        check($sformatf("rdata@%0h", addr), rdata, exp_rd_q.pop_front());
      end
    end
  end

  logic [159:0] mon_samp;
  int           mon_start;
  int           mon_bad;
  bit           mon_abort;
  logic [39:0]  mon_e;
  logic [7:0]   mon_byte;
  logic         mon_lvl;

  initial forever begin
    @(negedge clk);
    if (reset === 1'b1 && uart_tx === 1'b0) begin
      mon_start = cyc;
      mon_abort = 0;
      mon_samp  = '1;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge clk);
        if (reset !== 1'b1) begin
          mon_abort = 1;
          break;
        end
        mon_samp[i] = uart_tx;
      end
      if (!mon_abort) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: frame starting at cycle %0d, none expected", mon_start);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_bad = 0;
          for (int i = 0; i < FRAME; i++) begin
            if (i < BD)               mon_lvl = 1'b0;
            else if (i >= 9 * BD)     mon_lvl = 1'b1;
            else                      mon_lvl = mon_e[(i - BD) / BD];
            if (mon_samp[i] !== mon_lvl) mon_bad++;
          end
          for (int k = 0; k < 8; k++) mon_byte[k] = mon_samp[BD * (k + 1) + BD / 2];
          check("tx_start_cycle", mon_start, mon_e[39:8]);
          check("tx_byte", {24'h0, mon_byte}, {24'h0, mon_e[7:0]});
          check("tx_bad_bit_cycles", mon_bad, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: still running at cycle %0d, expected to have finished", cyc);
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  int          n_tx, n_valid;
  logic        first_done, later_done;
  logic [7:0]  b, b2;
  logic [31:0] ra;

  initial begin
    model_reset();

    // Reset with idle line
    reset = 1'b0; uart_rx = 1'b1;
    tick(4);
    @(negedge clk);
    check("reset_uart_tx", uart_tx, 1);
    check("reset_irq", irq_out, 0);
    reset = 1'b1;
    tick(2);
    bus_read(CON_A);
    bus_read(RXD_A);
    bus_read(TXD_A);
    addr = CON_A;
    @(negedge clk);
    check("rdata_without_rd", rdata, 0);
    tick(1);

    // TX of 0xA5 with tx_ie; upper CON write bits ignored; second write mid-frame dropped
    bus_write(CON_A, 32'hFFFF_FFFD);
    bus_write(TXD_A, 32'h0000_00A5);
    n_tx = cyc;
    tick(40);
    bus_read(CON_A);
    bus_write(TXD_A, 32'h0000_005A);
    while (cyc < n_tx + FRAME) @(negedge clk);
    check("irq_tx_before_latency", irq_out, 0);
    @(negedge clk);
    check("irq_tx_after_latency", irq_out, model_irq());
    tick(2);
    bus_read(CON_A);
    tick(3);
    @(negedge clk);
    check("irq_tx_cleared", irq_out, model_irq());
    tick(1);

    // RX of 0x3C with rx_ie; RXD read clears rx_valid and, a cycle later, irq
    bus_write(CON_A, 32'h2);
    send_rx(8'h3C, 1);
    tick(4);
    @(negedge clk);
    check("irq_rx_set", irq_out, model_irq());
    tick(1);
    bus_read(RXD_A);
    @(negedge clk);
    check("irq_rx_latency", irq_out, 1);
    @(negedge clk);
    check("irq_rx_cleared", irq_out, model_irq());
    tick(1);
    bus_read(CON_A);
    b = 8'($urandom);
    send_rx(b, 1);
    tick(4);
    bus_read(CON_A);
    bus_read(RXD_A);

    // Framing error and start-bit glitch leave RXD/rx_valid alone
    send_rx(8'($urandom), 0);
    tick(4);
    bus_read(CON_A);
    bus_read(RXD_A);
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(FRAME + 40);
    bus_read(CON_A);
    bus_read(RXD_A);

    // rx_valid set on the edge of a CON read survives; tx_done is cleared by the first read
    bus_write(CON_A, 32'h0);
    bus_write(TXD_A, 32'($urandom_range(0, 255)));
    tick(FRAME + 10);
    b2 = 8'($urandom);
    n_valid = 0; first_done = 1'b0; later_done = 1'b0;
    fork
      send_rx(b2, 1);
      begin
        tick(100);
        addr = CON_A; rd = 1'b1;
        for (int i = 0; i < 70; i++) begin
          @(negedge clk);
          if (rdata[3]) n_valid++;
          if (i == 0) first_done = rdata[2];
          else if (rdata[2]) later_done = 1'b1;
          tick(1);
        end
        rd = 1'b0;
      end
    join
    check("rx_valid_seen_once", n_valid, 1);
    check("tx_done_first_read", first_done, 1);
    check("tx_done_cleared_by_read", later_done, 0);
    model_advance();
    m_tx_done = 0; m_rx_valid = 0;
    bus_read(RXD_A);
    bus_read(CON_A);

    // Randomized rounds: enables, TX byte, RX byte, unmapped read
    for (int r = 0; r < 4; r++) begin
      bus_write(CON_A, {$urandom_range(0, 255), 2'($urandom_range(0, 3))} & 32'h3FF);
      bus_write(TXD_A, $urandom);
      tick(FRAME + $urandom_range(2, 20));
      send_rx(8'($urandom), 1);
      tick($urandom_range(3, 12));
      @(negedge clk);
      check("irq_random", irq_out, model_irq());
      tick(1);
      bus_read(CON_A);
      bus_read(RXD_A);
      ra = $urandom;
      if (ra == RXD_A || ra == CON_A) ra = ra ^ 32'h100;
      bus_read(ra);
    end

    // Reset in the middle of TX data bit 3 and of an RX frame
    bus_write(TXD_A, 32'($urandom_range(0, 255)) & 32'hF7);
    uart_rx = 1'b0;
    tick(4 * BD + BD / 2);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    tick(1);
    @(negedge clk);
    check("reset_mid_tx_line_high", uart_tx, 1);
    check("reset_mid_irq", irq_out, 0);
    uart_rx = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(3);
    bus_read(CON_A);
    bus_read(RXD_A);
    bus_write(TXD_A, $urandom);
    tick(FRAME + 30);

    check("tx_queue_drained", exp_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    summary();
    $finish;
  end

endmodule
